// File: rtl/spr_defs.sv
// SPR indices, mode values and sequencer state encoding shared by
// the interrupt entry/return logic.
package spr_defs;

    localparam logic [2:0] SPR_SR    = 3'd0;
    localparam logic [2:0] SPR_ESR   = 3'd1;
    localparam logic [2:0] SPR_ECA   = 3'd2;
    localparam logic [2:0] SPR_EPC   = 3'd3;
    localparam logic [2:0] SPR_EDATA = 3'd4;
    localparam logic [2:0] SPR_MODE  = 3'd5;
    localparam logic [2:0] SPR_EMODE = 3'd6;

    localparam logic [31:0] MODE_SYSTEM = 32'd0;
    localparam logic [31:0] MODE_USER   = 32'd1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        S_ESR   = 4'd1,
        S_ECA   = 4'd2,
        S_EPC   = 4'd3,
        S_EDATA = 4'd4,
        S_EMODE = 4'd5,
        S_CLRSR = 4'd6,
        S_MODE  = 4'd7,
        S_REDIR = 4'd8,
        R_SR    = 4'd9,
        R_MODE  = 4'd10,
        R_REDIR = 4'd11
    } state_t;

endpackage

// File: rtl/isr_sequencer.sv
// Sequences interrupt entry / eret through the single SPR write port,
// stalling the pipeline and issuing a PC redirect at the end.
module isr_sequencer
    import spr_defs::*;
#(
    parameter logic [31:0] SISR = 32'h0000_0000,
    parameter int          CA_W = 23
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jisr,
    input  logic [CA_W-1:0] mca,
    input  logic            rpt,
    input  logic [31:0]     pc,
    input  logic [31:0]     next_pc,
    input  logic [31:0]     ea,
    input  logic            eret,
    input  logic [31:0]     sr_in,
    input  logic [31:0]     mode_in,
    input  logic [31:0]     esr_in,
    input  logic [31:0]     emode_in,
    input  logic [31:0]     epc_in,
    output logic            spr_we,
    output logic [2:0]      spr_sel,
    output logic [31:0]     spr_wdata,
    output logic            stall,
    output logic            pc_redirect,
    output logic [31:0]     pc_target,
    output logic            busy,
    output logic [7:0]      int_count
);

    state_t      state, state_d;
    logic        pend;
    logic [31:0] sr_snap, mode_snap, mca_snap, epc_snap, ea_snap;
    logic [31:0] esr_snap, emode_snap, ret_snap;
    logic        take_live, take_ret, take_pend;
    logic [31:0] mca_ext, epc_live;

    assign mca_ext  = {{(32-CA_W){1'b0}}, mca};
    assign epc_live = rpt ? pc : next_pc;
    assign busy     = (state != IDLE);
    assign stall    = busy | jisr | eret;

    always_comb begin
        state_d   = state;
        take_live = 1'b0;
        take_ret  = 1'b0;
        take_pend = 1'b0;
        case (state)
            IDLE: begin
                if (jisr) begin
                    take_live = 1'b1;
                    state_d   = S_ESR;
                end else if (eret) begin
                    take_ret = 1'b1;
                    state_d  = R_SR;
                end
            end
            S_ESR:   state_d = S_ECA;
            S_ECA:   state_d = S_EPC;
            S_EPC:   state_d = S_EDATA;
            S_EDATA: state_d = S_EMODE;
            S_EMODE: state_d = S_CLRSR;
            S_CLRSR: state_d = S_MODE;
            S_MODE:  state_d = S_REDIR;
            S_REDIR: state_d = IDLE;
            R_SR: begin
                state_d   = R_MODE;
                take_pend = jisr & ~pend;
            end
            R_MODE: begin
                state_d   = R_REDIR;
                take_pend = jisr & ~pend;
            end
            R_REDIR: begin
                if (pend) begin
                    state_d = S_ESR;
                end else if (jisr) begin
                    take_live = 1'b1;
                    state_d   = S_ESR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        spr_we      = 1'b0;
        spr_sel     = 3'd0;
        spr_wdata   = 32'd0;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        case (state)
            S_ESR: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_ESR;
                spr_wdata = sr_snap;
            end
            S_ECA: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_ECA;
                spr_wdata = mca_snap;
            end
            S_EPC: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_EPC;
                spr_wdata = epc_snap;
            end
            S_EDATA: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_EDATA;
                spr_wdata = ea_snap;
            end
            S_EMODE: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_EMODE;
                spr_wdata = mode_snap;
            end
            S_CLRSR: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_SR;
                spr_wdata = 32'd0;
            end
            S_MODE: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_MODE;
                spr_wdata = MODE_SYSTEM;
            end
            S_REDIR: begin
                pc_redirect = 1'b1;
                pc_target   = SISR;
            end
            R_SR: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_SR;
                spr_wdata = esr_snap;
            end
            R_MODE: begin
                spr_we    = 1'b1;
                spr_sel   = SPR_MODE;
                spr_wdata = emode_snap;
            end
            R_REDIR: begin
                pc_redirect = 1'b1;
                pc_target   = ret_snap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= 1'b0;
            int_count  <= 8'd0;
            sr_snap    <= 32'd0;
            mode_snap  <= 32'd0;
            mca_snap   <= 32'd0;
            epc_snap   <= 32'd0;
            ea_snap    <= 32'd0;
            esr_snap   <= 32'd0;
            emode_snap <= 32'd0;
            ret_snap   <= 32'd0;
        end else begin
            state <= state_d;
            if (take_live) begin
                sr_snap   <= sr_in;
                mode_snap <= mode_in;
                mca_snap  <= mca_ext;
                epc_snap  <= epc_live;
                ea_snap   <= ea;
            end
            if (take_ret) begin
                esr_snap   <= esr_in;
                emode_snap <= emode_in;
                ret_snap   <= epc_in;
            end
            // Interrupt during return: save the context being restored
            if (take_pend) begin
                pend      <= 1'b1;
                sr_snap   <= esr_snap;
                mode_snap <= emode_snap;
                mca_snap  <= mca_ext;
                epc_snap  <= epc_live;
                ea_snap   <= ea;
            end
            if (take_live | take_pend) begin
                int_count <= int_count + 8'd1;
            end
            if (state == R_REDIR) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isr_sequencer.sv
// Directed self-checking bench for isr_sequencer entry/return sequencing.
module tb_isr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        jisr;
    logic [22:0] mca;
    logic        rpt;
    logic [31:0] pc, next_pc, ea;
    logic        eret;
    logic [31:0] sr_in, mode_in, esr_in, emode_in, epc_in;
    logic        spr_we;
    logic [2:0]  spr_sel;
    logic [31:0] spr_wdata;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        busy;
    logic [7:0]  int_count;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_cnt = 8'd0;

    isr_sequencer #(.SISR(32'h0000_0000), .CA_W(23)) dut (
        .clk(clk), .rst(rst), .jisr(jisr), .mca(mca), .rpt(rpt),
        .pc(pc), .next_pc(next_pc), .ea(ea), .eret(eret),
        .sr_in(sr_in), .mode_in(mode_in), .esr_in(esr_in),
        .emode_in(emode_in), .epc_in(epc_in),
        .spr_we(spr_we), .spr_sel(spr_sel), .spr_wdata(spr_wdata),
        .stall(stall), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .busy(busy), .int_count(int_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jisr = 0; eret = 0; mca = '0; rpt = 0;
        pc = 0; next_pc = 0; ea = 0;
        sr_in = 0; mode_in = 0; esr_in = 0; emode_in = 0; epc_in = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        cyc(); cyc();
        rst = 0;
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            checks++;
            if ({spr_we, spr_sel, spr_wdata, stall, pc_redirect,
                 pc_target, busy, int_count} !== '0) begin
                failures++;
                $display("FAIL reset_idle%0d: we=%0b sel=%0d wd=%h st=%0b rd=%0b tg=%h busy=%0b cnt=%0d want all 0",
                         i, spr_we, spr_sel, spr_wdata, stall,
                         pc_redirect, pc_target, busy, int_count);
            end
        end
    endtask

    task automatic test_entry(input logic r);
        logic [2:0]  es [7];
        logic [31:0] ed [7];
        es = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd5};
        ed = '{32'hFF, 32'h4, (r ? 32'h100 : 32'h104), 32'h2002,
               32'h1, 32'h0, 32'h0};
        cyc();
        jisr = 1; mca = 23'h000004; rpt = r;
        pc = 32'h100; next_pc = 32'h104; ea = 32'h2002;
        sr_in = 32'hFF; mode_in = 32'h1;
        #1;
        checks++;
        if ({stall, busy, spr_we} !== 3'b100) begin
            failures++;
            $display("FAIL entry_accept: stall=%0b busy=%0b we=%0b want 1 0 0",
                     stall, busy, spr_we);
        end
        exp_cnt++;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i == 0) begin
                clear_inputs();
            end
            jisr = (i == 1);
            #1;
            checks++;
            if ({spr_we, spr_sel, spr_wdata, stall, pc_redirect} !==
                {1'b1, es[i], ed[i], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL entry_write%0d rpt=%0b: we=%0b sel=%0d wd=%h st=%0b rd=%0b want sel=%0d wd=%h",
                         i, r, spr_we, spr_sel, spr_wdata, stall,
                         pc_redirect, es[i], ed[i]);
            end
        end
        cyc(); jisr = 0; #1;
        checks++;
        if ({pc_redirect, pc_target, spr_we, spr_wdata, stall} !==
            {1'b1, 32'h0, 1'b0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL entry_redirect: rd=%0b tg=%h we=%0b wd=%h st=%0b want 1 0 0 0 1",
                     pc_redirect, pc_target, spr_we, spr_wdata, stall);
        end
        cyc(); #1;
        checks++;
        if ({busy, stall, pc_redirect, int_count} !==
            {3'b000, exp_cnt}) begin
            failures++;
            $display("FAIL entry_done: busy=%0b st=%0b rd=%0b cnt=%0d want 0 0 0 %0d",
                     busy, stall, pc_redirect, int_count, exp_cnt);
        end
    endtask

    task automatic test_eret();
        cyc();
        eret = 1; esr_in = 32'hFF; emode_in = 32'h1; epc_in = 32'h104;
        #1;
        checks++;
        if ({stall, busy} !== 2'b10) begin
            failures++;
            $display("FAIL eret_accept: stall=%0b busy=%0b want 1 0",
                     stall, busy);
        end
        cyc(); clear_inputs(); #1;
        checks++;
        if ({spr_we, spr_sel, spr_wdata} !== {1'b1, 3'd0, 32'hFF}) begin
            failures++;
            $display("FAIL eret_sr: we=%0b sel=%0d wd=%h want 1 0 ff",
                     spr_we, spr_sel, spr_wdata);
        end
        cyc(); #1;
        checks++;
        if ({spr_we, spr_sel, spr_wdata} !== {1'b1, 3'd5, 32'h1}) begin
            failures++;
            $display("FAIL eret_mode: we=%0b sel=%0d wd=%h want 1 5 1",
                     spr_we, spr_sel, spr_wdata);
        end
        cyc(); #1;
        checks++;
        if ({pc_redirect, pc_target, spr_we, stall} !==
            {1'b1, 32'h104, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL eret_redirect: rd=%0b tg=%h we=%0b st=%0b want 1 104 0 1",
                     pc_redirect, pc_target, spr_we, stall);
        end
        cyc(); #1;
        checks++;
        if ({busy, stall, pc_redirect, int_count} !==
            {3'b000, exp_cnt}) begin
            failures++;
            $display("FAIL eret_done: busy=%0b st=%0b rd=%0b cnt=%0d want 0 0 0 %0d",
                     busy, stall, pc_redirect, int_count, exp_cnt);
        end
    endtask

    task automatic test_both();
        logic [2:0] es [7];
        es = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd5};
        cyc();
        jisr = 1; eret = 1; mca = 23'h2; next_pc = 32'h80;
        sr_in = 32'h3; mode_in = 32'h1;
        esr_in = 32'h77; emode_in = 32'h1; epc_in = 32'h99;
        #1;
        exp_cnt++;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i == 0) begin
                clear_inputs();
            end
            #1;
            checks++;
            if ({spr_we, spr_sel} !== {1'b1, es[i]}) begin
                failures++;
                $display("FAIL both_seq%0d: we=%0b sel=%0d want 1 %0d",
                         i, spr_we, spr_sel, es[i]);
            end
        end
        cyc(); #1;
        checks++;
        if ({pc_redirect, pc_target} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL both_redirect: rd=%0b tg=%h want 1 0",
                     pc_redirect, pc_target);
        end
        cyc(); #1;
        checks++;
        if ({busy, int_count} !== {1'b0, exp_cnt}) begin
            failures++;
            $display("FAIL both_done: busy=%0b cnt=%0d want 0 %0d",
                     busy, int_count, exp_cnt);
        end
    endtask

    task automatic test_jisr_in_ret();
        logic [2:0]  es [7];
        logic [31:0] ed [7];
        es = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd5};
        ed = '{32'h55, 32'h8, 32'h300, 32'h400, 32'h1, 32'h0, 32'h0};
        cyc();
        eret = 1; esr_in = 32'h55; emode_in = 32'h1; epc_in = 32'h200;
        #1;
        cyc();
        clear_inputs();
        jisr = 1; mca = 23'h8; rpt = 1; pc = 32'h300;
        next_pc = 32'h304; ea = 32'h400; sr_in = 32'hAA;
        #1;
        exp_cnt++;
        checks++;
        if ({spr_we, spr_sel, spr_wdata} !== {1'b1, 3'd0, 32'h55}) begin
            failures++;
            $display("FAIL pend_rsr: we=%0b sel=%0d wd=%h want 1 0 55",
                     spr_we, spr_sel, spr_wdata);
        end
        cyc();
        mca = 23'h10; pc = 32'h500; ea = 32'h600;
        #1;
        checks++;
        if ({spr_we, spr_sel, spr_wdata} !== {1'b1, 3'd5, 32'h1}) begin
            failures++;
            $display("FAIL pend_rmode: we=%0b sel=%0d wd=%h want 1 5 1",
                     spr_we, spr_sel, spr_wdata);
        end
        cyc(); clear_inputs(); #1;
        checks++;
        if ({pc_redirect, pc_target, spr_we} !== {1'b1, 32'h200, 1'b0}) begin
            failures++;
            $display("FAIL pend_rredir: rd=%0b tg=%h we=%0b want 1 200 0",
                     pc_redirect, pc_target, spr_we);
        end
        for (int i = 0; i < 7; i++) begin
            cyc(); #1;
            checks++;
            if ({spr_we, spr_sel, spr_wdata} !== {1'b1, es[i], ed[i]}) begin
                failures++;
                $display("FAIL pend_write%0d: we=%0b sel=%0d wd=%h want sel=%0d wd=%h",
                         i, spr_we, spr_sel, spr_wdata, es[i], ed[i]);
            end
        end
        cyc(); #1;
        checks++;
        if ({pc_redirect, pc_target} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL pend_redirect: rd=%0b tg=%h want 1 0",
                     pc_redirect, pc_target);
        end
        cyc(); #1;
        checks++;
        if ({busy, int_count} !== {1'b0, exp_cnt}) begin
            failures++;
            $display("FAIL pend_done: busy=%0b cnt=%0d want 0 %0d",
                     busy, int_count, exp_cnt);
        end
    endtask

    task automatic test_jisr_at_redir();
        logic [2:0]  es [5];
        logic [31:0] ed [5];
        es = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        ed = '{32'h22, 32'h1, 32'h44, 32'h88, 32'h1};
        cyc();
        eret = 1; esr_in = 32'h11; emode_in = 32'h0; epc_in = 32'h40;
        #1;
        cyc(); clear_inputs(); #1;
        cyc(); #1;
        cyc();
        jisr = 1; sr_in = 32'h22; mode_in = 32'h1; mca = 23'h1;
        rpt = 0; pc = 32'h40; next_pc = 32'h44; ea = 32'h88;
        #1;
        exp_cnt++;
        checks++;
        if ({pc_redirect, pc_target} !== {1'b1, 32'h40}) begin
            failures++;
            $display("FAIL live_rredir: rd=%0b tg=%h want 1 40",
                     pc_redirect, pc_target);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                clear_inputs();
            end
            #1;
            checks++;
            if ({spr_we, spr_sel, spr_wdata} !== {1'b1, es[i], ed[i]}) begin
                failures++;
                $display("FAIL live_write%0d: we=%0b sel=%0d wd=%h want sel=%0d wd=%h",
                         i, spr_we, spr_sel, spr_wdata, es[i], ed[i]);
            end
        end
        cyc(); cyc(); cyc(); cyc(); #1;
        checks++;
        if ({busy, int_count} !== {1'b0, exp_cnt}) begin
            failures++;
            $display("FAIL live_done: busy=%0b cnt=%0d want 0 %0d",
                     busy, int_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        jisr = 1; mca = 23'h4; next_pc = 32'h104; ea = 32'h2002;
        sr_in = 32'hFF; mode_in = 32'h1;
        #1;
        cyc(); clear_inputs();
        cyc();
        cyc(); #1;
        checks++;
        if ({spr_we, spr_sel, spr_wdata} !== {1'b1, 3'd3, 32'h104}) begin
            failures++;
            $display("FAIL rstmid_epc: we=%0b sel=%0d wd=%h want 1 3 104",
                     spr_we, spr_sel, spr_wdata);
        end
        rst = 1;
        cyc();
        rst = 0;
        exp_cnt = 0;
        #1;
        checks++;
        if ({spr_we, spr_sel, spr_wdata, stall, pc_redirect,
             pc_target, busy, int_count} !== '0) begin
            failures++;
            $display("FAIL rstmid_idle: we=%0b sel=%0d wd=%h st=%0b rd=%0b tg=%h busy=%0b cnt=%0d want all 0",
                     spr_we, spr_sel, spr_wdata, stall, pc_redirect,
                     pc_target, busy, int_count);
        end
        cyc(); #1;
        checks++;
        if ({busy, spr_we, stall} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_stay: busy=%0b we=%0b st=%0b want 0 0 0",
                     busy, spr_we, stall);
        end
    endtask

    initial begin
        test_reset();
        test_entry(1'b0);
        test_entry(1'b1);
        test_eret();
        test_both();
        test_jisr_in_ret();
        test_jisr_at_redir();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
